// File: rtl/rf_inflight_tracker.sv
// rf_inflight_tracker: tracks in-flight RF writes per pipe (even/odd) from issue to writeback
// Ports: clk, rst (async, active-low), flush; iss_wr/rt/idx for each pipe from issue;
//   rf_addr/rf_idx per stage 1..NUM_STAGES-1 per pipe (0 when the stage is empty);
//   wb_valid/wb_addr per pipe at stage NUM_STAGES; wb_conflict when both pipes write one register;
//   busy_vec per register, decoded only when RF_INFLIGHT_BUSY_VEC_EN is defined, else 128'd0.
module rf_inflight_tracker #(
  parameter int NUM_STAGES  = 7,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            iss_wr_ep,
  input  logic [0:6]                      iss_rt_ep,
  input  logic [0:2]                      iss_idx_ep,
  input  logic                            iss_wr_op,
  input  logic [0:6]                      iss_rt_op,
  input  logic [0:2]                      iss_idx_op,
  output logic [1:NUM_STAGES-1][0:6]      rf_addr_ep,
  output logic [1:NUM_STAGES-1][0:2]      rf_idx_ep,
  output logic [1:NUM_STAGES-1][0:6]      rf_addr_op,
  output logic [1:NUM_STAGES-1][0:2]      rf_idx_op,
  output logic                            wb_valid_ep,
  output logic [0:6]                      wb_addr_ep,
  output logic                            wb_valid_op,
  output logic [0:6]                      wb_addr_op,
  output logic                            wb_conflict,
  output logic [0:127]                    busy_vec
);
  logic [1:NUM_STAGES]            v_ep, v_op;
  logic [1:NUM_STAGES][0:6]       rt_ep, rt_op;
  logic [1:NUM_STAGES-1][0:2]     idx_ep, idx_op;
  logic                           ld_ep, ld_op;
  assign ld_ep = iss_wr_ep && iss_idx_ep != 3'd0 && !flush;
  assign ld_op = iss_wr_op && iss_idx_op != 3'd0 && !flush;
  // Empty entries hold zero rt/idx so the per-stage outputs never expose stale data.
  // Entries sitting in stages 1..FLUSH_DEPTH are dropped instead of shifted on flush.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_ep   <= '0;
      v_op   <= '0;
      rt_ep  <= '0;
      rt_op  <= '0;
      idx_ep <= '0;
      idx_op <= '0;
    end else begin
      v_ep[1]   <= ld_ep;
      rt_ep[1]  <= ld_ep ? iss_rt_ep : 7'd0;
      idx_ep[1] <= ld_ep ? iss_idx_ep : 3'd0;
      v_op[1]   <= ld_op;
      rt_op[1]  <= ld_op ? iss_rt_op : 7'd0;
      idx_op[1] <= ld_op ? iss_idx_op : 3'd0;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        v_ep[k]  <= (flush && k - 1 <= FLUSH_DEPTH) ? 1'b0 : v_ep[k-1];
        rt_ep[k] <= (flush && k - 1 <= FLUSH_DEPTH) ? 7'd0 : rt_ep[k-1];
        v_op[k]  <= (flush && k - 1 <= FLUSH_DEPTH) ? 1'b0 : v_op[k-1];
        rt_op[k] <= (flush && k - 1 <= FLUSH_DEPTH) ? 7'd0 : rt_op[k-1];
      end
      for (int k = 2; k < NUM_STAGES; k++) begin
        idx_ep[k] <= (flush && k - 1 <= FLUSH_DEPTH) ? 3'd0 : idx_ep[k-1];
        idx_op[k] <= (flush && k - 1 <= FLUSH_DEPTH) ? 3'd0 : idx_op[k-1];
      end
    end
  assign rf_addr_ep  = rt_ep[1:NUM_STAGES-1];
  assign rf_addr_op  = rt_op[1:NUM_STAGES-1];
  assign rf_idx_ep   = idx_ep;
  assign rf_idx_op   = idx_op;
  assign wb_valid_ep = v_ep[NUM_STAGES];
  assign wb_valid_op = v_op[NUM_STAGES];
  assign wb_addr_ep  = rt_ep[NUM_STAGES];
  assign wb_addr_op  = rt_op[NUM_STAGES];
  assign wb_conflict = wb_valid_ep && wb_valid_op && wb_addr_ep == wb_addr_op;
`ifdef RF_INFLIGHT_BUSY_VEC_EN
  always_comb begin
    busy_vec = '0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (v_ep[k]) busy_vec[rt_ep[k]] = 1'b1;
      if (v_op[k]) busy_vec[rt_op[k]] = 1'b1;
    end
  end
`else
  assign busy_vec = '0;
`endif
endmodule
